// File: rtl/pio_ts_pkg.sv
// Shared definitions for the PIO change timestamper.
// Holds the Avalon register addresses, the bit positions used in the status
// and control registers, and the layout of one FIFO record.
package pio_ts_pkg;

  // Widths fixed by the register map
  localparam int REG_W = 32;
  localparam int VAL_W = 8;

  // Register word addresses
  localparam logic [1:0] ADDR_COUNTER = 2'd0;
  localparam logic [1:0] ADDR_HEAD_TS = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  // Control register bits (addr3)
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Status register fields (addr2, read)
  localparam int ST_VAL_LSB   = 0;
  localparam int ST_VAL_MSB   = 7;
  localparam int ST_LEVEL_LSB = 8;
  localparam int ST_LEVEL_MSB = 15;
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_OVERFLOW  = 18;

  // Status register command bits (addr2, write)
  localparam int CMD_POP     = 0;
  localparam int CMD_OVF_CLR = 1;

  // One FIFO record: timestamp in the upper bits, port value in the lower bits
  typedef struct packed {
    logic [REG_W-1:0] ts;
    logic [VAL_W-1:0] val;
  } fifo_entry_t;

endpackage

// File: rtl/pio_change_timestamper_if.sv
// Avalon-MM slave bus of the PIO change timestamper.
//   address    : word address (2 bits)
//   chipselect : slave select
//   read_n     : read strobe, active-low
//   write_n    : write strobe, active-low
//   writedata  : write data
//   readdata   : read data, combinational, zero wait states
// Handshake: a write occurs on every clock edge where chipselect=1 and
// write_n=0; readdata is valid in the same cycle whenever chipselect=1 and
// read_n=0 and is 0 otherwise. There is no waitrequest.
interface pio_change_timestamper_if;
  import pio_ts_pkg::*;

  logic [1:0]       address;
  logic             chipselect;
  logic             read_n;
  logic             write_n;
  logic [REG_W-1:0] writedata;
  logic [REG_W-1:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_ts_fifo.sv
// Single-clock synchronous FIFO used to queue timestamped change records.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_push        : write i_push_data at the tail
//   i_pop         : advance the head (ignored when empty)
//   i_ovf_clr     : clear the sticky overflow flag
//   o_head_data   : entry at the head, combinational
//   o_level       : number of stored entries
//   o_empty/o_full: occupancy flags
//   o_overflow    : sticky, set when a push is dropped
module pio_ts_fifo
  import pio_ts_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_ovf_clr,
  output logic [WIDTH-1:0]         o_head_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_overflow;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_drop;

  assign o_empty     = (r_level == '0);
  assign o_full      = (r_level == FULL_LEVEL);
  assign o_level     = r_level;
  assign o_overflow  = r_overflow;
  assign o_head_data = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign w_drop    = i_push & ~w_push_ok;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push_ok && !w_pop_ok)      r_level <= r_level + LVL_ONE;
      else if (!w_push_ok && w_pop_ok) r_level <= r_level - LVL_ONE;
      // A drop in the same cycle as a clear leaves the flag set
      if (w_drop)         r_overflow <= 1'b1;
      else if (i_ovf_clr) r_overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/pio_change_timestamper.sv
// Watches an 8-bit PIO output port and records every value change together
// with a free-running cycle timestamp in a FIFO readable over Avalon-MM.
//   clk, reset_n : clock, asynchronous active-low reset
//   pio_in       : value driven by the upstream PIO out_port
//   bus          : Avalon-MM slave (counter, head timestamp, status, control)
//   echo_out     : pio_in delayed by one clock, for loop-back measurements
//   irq          : level interrupt while the FIFO is non-empty and enabled
module pio_change_timestamper
  import pio_ts_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       pio_in,
  pio_change_timestamper_if.slave bus,
  output logic [DATA_W-1:0]       echo_out,
  output logic                    irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]   r_counter;
  logic [DATA_W-1:0] r_pio_prev;
  logic              r_enable;
  logic              r_irq_en;
  logic              r_irq;

  logic              w_wr;
  logic              w_rd;
  logic              w_counter_clr;
  logic              w_pop;
  logic              w_ovf_clr;
  logic              w_ctrl_wr;
  logic              w_event;
  fifo_entry_t       w_push_entry;
  fifo_entry_t       w_head_entry;
  logic [LVL_W-1:0]  w_level;
  logic              w_empty;
  logic              w_full;
  logic              w_overflow;
  logic [REG_W-1:0]  w_rdata;
  logic              w_unused_wdata;

  assign w_wr          = bus.chipselect & ~bus.write_n;
  assign w_rd          = bus.chipselect & ~bus.read_n;
  assign w_counter_clr = w_wr & (bus.address == ADDR_COUNTER);
  assign w_pop         = w_wr & (bus.address == ADDR_STATUS) & bus.writedata[CMD_POP];
  assign w_ovf_clr     = w_wr & (bus.address == ADDR_STATUS) & bus.writedata[CMD_OVF_CLR];
  assign w_ctrl_wr     = w_wr & (bus.address == ADDR_CTRL);
  assign w_unused_wdata = &{1'b0, bus.writedata[REG_W-1:2]};

  // pio_prev tracks the port even while disabled, so re-enabling compares
  // against the current value and cannot fire a stale event.
  assign w_event      = r_enable & (pio_in != r_pio_prev);
  assign w_push_entry = '{ts: REG_W'(r_counter), val: VAL_W'(pio_in)};

  pio_ts_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_event),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_ovf_clr   (w_ovf_clr),
    .o_head_data (w_head_entry),
    .o_level     (w_level),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_overflow  (w_overflow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter  <= '0;
      r_pio_prev <= '0;
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_pio_prev <= pio_in;
      if (w_counter_clr)  r_counter <= '0;
      else if (r_enable)  r_counter <= r_counter + TS_W'(1);
      if (w_ctrl_wr) begin
        r_enable <= bus.writedata[CTRL_ENABLE];
        r_irq_en <= bus.writedata[CTRL_IRQ_EN];
      end
      r_irq <= r_irq_en & ~w_empty;
    end
  end

  assign echo_out = r_pio_prev;
  assign irq      = r_irq;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (bus.address)
        ADDR_COUNTER: w_rdata = REG_W'(r_counter);
        ADDR_HEAD_TS: w_rdata = w_head_entry.ts;
        ADDR_STATUS: begin
          w_rdata[ST_VAL_MSB:ST_VAL_LSB]     = w_head_entry.val;
          w_rdata[ST_LEVEL_MSB:ST_LEVEL_LSB] = 8'(w_level);
          w_rdata[ST_EMPTY]                  = w_empty;
          w_rdata[ST_FULL]                   = w_full;
          w_rdata[ST_OVERFLOW]               = w_overflow;
        end
        ADDR_CTRL: begin
          w_rdata[CTRL_ENABLE] = r_enable;
          w_rdata[CTRL_IRQ_EN] = r_irq_en;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.readdata = w_rdata;

endmodule

// File: tb/tb_pio_change_timestamper.sv
`timescale 1ns/1ps
module tb_pio_change_timestamper;
  import pio_ts_pkg::*;

  localparam int DEPTH = 16;
  localparam int W     = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pio_in = 8'h00;
  logic [7:0] echo_out;
  logic       irq;

  always #5 clk = ~clk;

  pio_change_timestamper_if bus_if ();

  pio_change_timestamper #(
    .DEPTH  (DEPTH),
    .TS_W   (32),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pio_in   (pio_in),
    .bus      (bus_if),
    .echo_out (echo_out),
    .irq      (irq)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];   // pending records {ts, val}, head at index 0
  logic [31:0]  m_counter;
  logic [7:0]   m_prev;
  logic         m_en;
  logic         m_irq_en;
  logic         m_ovf;
  logic         m_irq;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_counter = '0;
    m_prev    = '0;
    m_en      = 1'b0;
    m_irq_en  = 1'b0;
    m_ovf     = 1'b0;
    m_irq     = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0]  s;
    logic [W-1:0] h;
    s = '0;
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      s[7:0] = h[7:0];
    end
    s[15:8] = 8'(exp_q.size());
    s[16]   = (exp_q.size() == 0);
    s[17]   = (exp_q.size() == DEPTH);
    s[18]   = m_ovf;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus_if.chipselect = 1'b0;
    bus_if.read_n     = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd0;
    bus_if.writedata  = '0;
  endtask

  // One clock: advance the model from the inputs present at the edge, then
  // compare the registered outputs just after the edge.
  task automatic tick();
    bit          wr, ev, pop_ok, drop;
    bit          nxt_irq;
    logic [31:0] nxt_cnt;
    wr      = bus_if.chipselect && !bus_if.write_n;
    nxt_irq = m_irq_en && (exp_q.size() != 0);
    if (wr && bus_if.address == ADDR_COUNTER) nxt_cnt = '0;
    else if (m_en)                           nxt_cnt = m_counter + 32'd1;
    else                                     nxt_cnt = m_counter;
    ev     = m_en && (pio_in != m_prev);
    pop_ok = wr && bus_if.address == ADDR_STATUS && bus_if.writedata[0] && exp_q.size() != 0;
    if (pop_ok) void'(exp_q.pop_front());
    drop = 1'b0;
    if (ev) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_counter, pio_in});
      else                      drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (wr && bus_if.address == ADDR_STATUS && bus_if.writedata[1]) m_ovf = 1'b0;
    if (wr && bus_if.address == ADDR_CTRL) begin
      m_en     = bus_if.writedata[0];
      m_irq_en = bus_if.writedata[1];
    end
    m_prev    = pio_in;
    m_counter = nxt_cnt;
    m_irq     = nxt_irq;
    @(posedge clk);
    #1;
    check_eq("echo", 32'(echo_out), 32'(m_prev));
    check_eq("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.read_n     = 1'b1;
    bus_if.address    = a;
    bus_if.writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.read_n     = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = a;
    #1;
    d = bus_if.readdata;
    bus_idle();
  endtask

  // Read one register and compare it with the model. The head timestamp is
  // skipped and the head value masked while the FIFO is empty.
  task automatic check_read(input string tag, input logic [1:0] a);
    logic [31:0] d;
    bus_read(a, d);
    case (a)
      ADDR_COUNTER: check_eq({tag, "_cnt"}, d, m_counter);
      ADDR_HEAD_TS: if (exp_q.size() != 0) check_eq({tag, "_ts"}, d, exp_q[0][39:8]);
      ADDR_STATUS: begin
        if (exp_q.size() == 0) d[7:0] = 8'h00;
        check_eq({tag, "_st"}, d, exp_status());
      end
      default: check_eq({tag, "_ctrl"}, d, {30'd0, m_irq_en, m_en});
    endcase
  endtask

  function automatic logic [7:0] new_value(input logic [7:0] old);
    return old ^ 8'($urandom_range(1, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] n_stamp;
    logic [31:0] held;

    bus_idle();
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_echo", 32'(echo_out), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_idle_rd", bus_if.readdata, 32'h0);
    bus_read(ADDR_COUNTER, d); check_eq("rst_cnt", d, 32'h0);
    bus_read(ADDR_STATUS, d);  d[7:0] = 8'h00; check_eq("rst_st", d, 32'h0001_0000);
    bus_read(ADDR_CTRL, d);    check_eq("rst_ctrl", d, 32'h0);
    reset_n = 1'b1;

    // first change stamped with the counter of its own cycle
    bus_write(ADDR_CTRL, 32'h1);
    repeat (10) tick();
    n_stamp = m_counter;
    pio_in  = 8'h5A;
    tick();
    bus_read(ADDR_STATUS, d);  check_eq("t1_status", d, 32'h0000_015A);
    bus_read(ADDR_HEAD_TS, d); check_eq("t1_head_ts", d, n_stamp);
    check_eq("t1_echo", 32'(echo_out), 32'h5A);

    // disabled: changes ignored, counter holds, re-enable has no event
    bus_write(ADDR_STATUS, 32'h1);
    bus_write(ADDR_CTRL, 32'h0);
    held = m_counter;
    pio_in = 8'h00; tick();
    pio_in = 8'hFF; tick();
    pio_in = 8'h00; tick();
    bus_read(ADDR_STATUS, d); d[7:0] = 8'h00; check_eq("t2_status", d, 32'h0001_0000);
    bus_read(ADDR_COUNTER, d); check_eq("t2_held", d, held);
    bus_write(ADDR_CTRL, 32'h1);
    tick();
    bus_read(ADDR_COUNTER, d); check_eq("t2_resume", d, held + 32'd1);
    bus_read(ADDR_STATUS, d); d[7:0] = 8'h00; check_eq("t2_no_event", d, 32'h0001_0000);

    // overflow: 17 changes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      pio_in = new_value(pio_in);
      tick();
    end
    bus_read(ADDR_STATUS, d);
    check_eq("t3_level", 32'(d[15:8]), 32'd16);
    check_eq("t3_full", 32'(d[17]), 32'd1);
    check_eq("t3_ovf", 32'(d[18]), 32'd1);
    check_read("t3", ADDR_STATUS);
    check_read("t3", ADDR_HEAD_TS);
    bus_write(ADDR_STATUS, 32'h1);
    bus_write(ADDR_STATUS, 32'h2);
    bus_read(ADDR_STATUS, d);
    check_eq("t3_ovf_clr", 32'(d[18]), 32'd0);
    check_eq("t3_level15", 32'(d[15:8]), 32'd15);
    while (exp_q.size() > 3) begin
      check_read("t3_drain", ADDR_HEAD_TS);
      check_read("t3_drain", ADDR_STATUS);
      bus_write(ADDR_STATUS, 32'h1);
    end

    // pop and push in the same cycle
    pio_in = new_value(pio_in);
    bus_write(ADDR_STATUS, 32'h1);
    bus_read(ADDR_STATUS, d); check_eq("t4_level", 32'(d[15:8]), 32'd3);
    while (exp_q.size() > 0) begin
      check_read("t4_order", ADDR_HEAD_TS);
      check_read("t4_order", ADDR_STATUS);
      if (exp_q.size() == 1) begin
        bus_read(ADDR_STATUS, d); check_eq("t4_tail_val", 32'(d[7:0]), 32'(pio_in));
      end
      bus_write(ADDR_STATUS, 32'h1);
    end

    // counter clear and wrap
    bus_write(ADDR_COUNTER, 32'h0);
    repeat (3) tick();
    bus_read(ADDR_COUNTER, d); check_eq("t5_cleared", d, 32'd3);
    force dut.r_counter = 32'hFFFF_FFFF;
    #1;
    release dut.r_counter;
    m_counter = 32'hFFFF_FFFF;
    bus_read(ADDR_COUNTER, d); check_eq("t5_preload", d, 32'hFFFF_FFFF);
    pio_in = new_value(pio_in);
    tick();
    bus_read(ADDR_COUNTER, d); check_eq("t5_wrap", d, 32'h0);
    bus_read(ADDR_HEAD_TS, d); check_eq("t5_wrap_ts", d, 32'hFFFF_FFFF);
    bus_write(ADDR_STATUS, 32'h1);

    // interrupt timing
    bus_write(ADDR_CTRL, 32'h3);
    pio_in = new_value(pio_in);
    tick();
    check_eq("t6_irq_lag", 32'(irq), 32'd0);
    tick();
    check_eq("t6_irq_up", 32'(irq), 32'd1);
    bus_write(ADDR_STATUS, 32'h1);
    check_eq("t6_irq_hold", 32'(irq), 32'd1);
    tick();
    check_eq("t6_irq_down", 32'(irq), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      if ($urandom_range(0, 2) == 0) pio_in = 8'($urandom);
      r = $urandom_range(0, 19);
      if (r < 3)       bus_write(ADDR_STATUS, 32'($urandom_range(0, 3)) | 32'h1);
      else if (r == 3) bus_write(ADDR_STATUS, 32'h2);
      else if (r == 4) bus_write(ADDR_COUNTER, $urandom);
      else if (r == 5) bus_write(ADDR_CTRL, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h3);
      else begin
        check_read("rnd", 2'($urandom_range(0, 3)));
        tick();
      end
    end

    // reset in the middle of traffic
    bus_write(ADDR_CTRL, 32'h3);
    pio_in = new_value(pio_in); tick();
    pio_in = new_value(pio_in); tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("t7_irq", 32'(irq), 32'h0);
    check_eq("t7_echo", 32'(echo_out), 32'h0);
    bus_read(ADDR_STATUS, d); d[7:0] = 8'h00; check_eq("t7_status", d, 32'h0001_0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    pio_in  = 8'h00;
    tick();
    check_read("t7_after", ADDR_CTRL);
    check_read("t7_after", ADDR_COUNTER);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pio_change_timestamper.md
Name: pio_change_timestamper

Overview:
- Sits directly downstream of the 8-bit Avalon-MM PIO output port.
- Watches that port, records every value change with a free-running cycle timestamp, and queues the records in a small FIFO.
- Software on the HPS/ARM side reads the FIFO over its own Avalon-MM slave and computes ARM-to-FPGA latency.
- A registered echo of the port is provided so it can be looped back to an input PIO for round-trip measurement.

Parameters:
- DEPTH, 16: FIFO entries. Power of two, 2..128.
- TS_W, 32: timestamp/counter width. Fixed at 32 for the register map.
- DATA_W, 8: width of the watched PIO port.

Ports:
- clk  in  1: system clock. pio_in and the Avalon bus are synchronous to it.
- reset_n  in  1: reset, asynchronous, active-low.
- pio_in  in  DATA_W: value driven by the upstream PIO out_port.
- address  in  2: Avalon word address.
- chipselect  in  1: Avalon slave select.
- read_n  in  1: Avalon read strobe, active-low.
- write_n  in  1: Avalon write strobe, active-low.
- writedata  in  32: Avalon write data.
- readdata  out  32: Avalon read data. Combinational, zero wait states, read latency 0.
- echo_out  out  DATA_W: pio_in delayed by one clk.
- irq  out  1: level interrupt, asserted while the FIFO is non-empty and enabled.

Behaviour:
Reset values (all outputs and state):
- counter, pio_prev, echo_out, ctrl, FIFO pointers, level and overflow all reset to 0.
- irq and readdata reset to 0.

Counter:
- Increments by 1 every clk while ctrl.enable=1. Wraps 0xFFFFFFFF -> 0.
- Holds its value while disabled.
- Any write to addr0 sets it to 0 on the next edge. Clear wins over increment in the same cycle.

Change detect:
- pio_prev <= pio_in every cycle, regardless of enable.
- echo_out is the same register as pio_prev.
- event = enable & (pio_in != pio_prev).
- On an event, push {counter value of that same cycle, pio_in}.
- Re-enabling never creates a spurious event, because pio_prev keeps tracking while disabled.

FIFO:
- Push on event. Pop on a write to addr2 with writedata[0]=1.
- Push+pop in the same cycle when non-empty: both happen, level unchanged.
- Push while full with no pop: record dropped, overflow sticky bit set.
- Push while full with a simultaneous pop: record accepted.
- Pop while empty: ignored. Pop+push while empty: push only.
- Head data is visible combinationally; a pop advances the head on the next edge.

Register map (reads are side-effect free):
- addr0 R: live counter. W: clear counter.
- addr1 R: head timestamp. Value is undefined (don't-care) when empty; the bench must not check it. W: ignored.
- addr2 R: [7:0] head value, [15:8] level, [16] empty, [17] full, [18] overflow, others 0.
- addr2 W: bit0=1 pops, bit1=1 clears overflow. If a clear and an overflow-set coincide, set wins.
- addr3 R/W: [0] enable, [1] irq_en, others read 0.
- A write is chipselect & ~write_n. readdata is valid whenever chipselect & ~read_n, otherwise 0.

Interrupt:
- irq = ctrl.irq_en & ~empty, registered (one-cycle lag after push or pop).

Reset mid-operation:
- Asynchronously clears everything, including FIFO contents (level=0) and overflow.
- The first value seen after reset_n deasserts is compared against pio_prev=0.

Decomposition:
- Package pio_ts_pkg holds:
  - register address constants ADDR_COUNTER=0, ADDR_HEAD_TS=1, ADDR_STATUS=2, ADDR_CTRL=3;
  - status/ctrl bit positions;
  - the FIFO entry struct {ts[31:0], val[7:0]}.
- One sub-module, pio_ts_fifo: synchronous single-clock FIFO with DEPTH and WIDTH=TS_W+DATA_W, push/pop/full/empty/level/overflow.
- The top level holds the counter, change detect, register decode and irq.

Test Plan:
- Reset, then write addr3=0x1. Hold pio_in=0 for 10 cycles, then drive 0x5A at counter=N. Expect addr2 = level 1, value 0x5A; addr1=N; echo_out=0x5A one cycle later.
- With enable=0, toggle pio_in 0x00->0xFF->0x00. Expect level 0. Then write enable=1 with pio_in steady: no event, counter starts from its held value.
- DEPTH=16: generate 17 changes. Expect full=1, level=16, overflow=1, and the 17th record absent. Pop once, then write addr2=0x2: overflow=0, level=15.
- With level=3, pop and change pio_in in the same cycle. Expect level stays 3 and the new record is at the tail in order.
- Write addr0 while enabled. Expect the next addr0 read to be small (cycles since clear). Force the counter to 0xFFFFFFFF via testbench preload: next value 0.
- Set irq_en=1. Expect irq rises one cycle after the first push and falls one cycle after popping the last entry. Assert reset_n low mid-stream: irq=0, level=0, echo_out=0 immediately.
